// File: rtl/mult_datapath.sv
// mult_datapath: operand latch, step counter and shift-accumulate datapath for the 8x8 sequential multiplier
// Ports:
//   clk, reset_a         clock and synchronous active-high reset
//   dataa, datab         operands, latched on a clear event (clk_ena=1, sclr_n=0)
//   input_sel, shift_sel nibble-pair and partial-product shift selects for a step event
//   clk_ena, sclr_n      step enable and active-low clear (clear only while clk_ena=1)
//   done, result_ack     capture strobe and consumer acknowledge for the product register
//   count, accum         step counter and running accumulator
//   product              final product with result_valid handshake
//   overrun, sel_err     sticky flags: unconsumed result overwritten, reserved shift used in a step
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_a,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    input  logic [1:0]           input_sel,
    input  logic [1:0]           shift_sel,
    input  logic                 clk_ena,
    input  logic                 sclr_n,
    input  logic                 done,
    input  logic                 result_ack,
    output logic [1:0]           count,
    output logic [2*WIDTH-1:0]   accum,
    output logic [2*WIDTH-1:0]   product,
    output logic                 result_valid,
    output logic                 overrun,
    output logic                 sel_err
);
    localparam int H = WIDTH / 2;
    logic [WIDTH-1:0]   opa, opb;
    logic [H-1:0]       na, nb;
    logic [WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0] pp_ext, shifted;
    // input_sel[1] picks the opa nibble, input_sel[0] the opb nibble
    always_comb begin
        na      = input_sel[1] ? opa[WIDTH-1:H] : opa[H-1:0];
        nb      = input_sel[0] ? opb[WIDTH-1:H] : opb[H-1:0];
        pp      = WIDTH'(na) * WIDTH'(nb);
        pp_ext  = (2*WIDTH)'(pp);
        shifted = shift_sel == 2'd0 ? pp_ext :
                  shift_sel == 2'd1 ? pp_ext << H :
                  shift_sel == 2'd2 ? pp_ext << WIDTH : '0;
    end
    always_ff @(posedge clk) begin
        if (reset_a) begin
            opa          <= '0;
            opb          <= '0;
            count        <= '0;
            accum        <= '0;
            product      <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            if (clk_ena && !sclr_n) begin
                opa     <= dataa;
                opb     <= datab;
                accum   <= '0;
                count   <= '0;
                sel_err <= 1'b0;
            end else if (clk_ena) begin
                count <= count + 2'd1;
                accum <= accum + shifted;
                if (shift_sel == 2'd3) sel_err <= 1'b1;
            end
            // a capture beats a simultaneous ack; only an un-acked live result counts as overrun
            if (done) begin
                product      <= accum;
                result_valid <= 1'b1;
                if (result_valid && !result_ack) overrun <= 1'b1;
            end else if (result_ack) begin
                result_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Datapath stage directly downstream of the 8x8 sequential multiplier control FSM.
- Latches two 8-bit operands and runs the 2-bit step counter that the FSM reads back.
- Each enabled cycle it forms one 4x4 partial product, shifts it and adds it into a 16-bit accumulator.
- On the FSM's done strobe it posts the final product into a result register with a valid/ack handshake.

Parameters:
- WIDTH, 8, operand width; nibble width is WIDTH/2. Only 8 is supported; other values are out of scope.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_a  in  1  synchronous, active-high reset
- dataa  in  8  multiplicand
- datab  in  8  multiplier
- input_sel  in  2  nibble-pair select from control
- shift_sel  in  2  partial-product shift select from control
- clk_ena  in  1  step enable from control
- sclr_n  in  1  active-low synchronous clear, qualified by clk_ena
- done  in  1  calculation-complete strobe from control
- result_ack  in  1  consumer accepts result
- count  out  2  step counter, fed back to control
- accum  out  16  running accumulator
- product  out  16  registered final product
- result_valid  out  1  product holds an unconsumed result
- overrun  out  1  sticky: a new result overwrote an unconsumed one
- sel_err  out  1  sticky: reserved shift_sel used while clk_ena=1

Behaviour:
- Reset (reset_a=1 at the clock edge): count, accum, the operand registers, product, result_valid, overrun and sel_err all go to 0. Reset overrides every other input. Reset mid-operation aborts the operation and returns the block to the all-zero state.
- Clear event, when clk_ena=1 and sclr_n=0:
  - dataa and datab are captured into the operand registers (opa, opb).
  - accum, count and sel_err are set to 0.
  - product, result_valid and overrun are unaffected.
- Step event, when clk_ena=1 and sclr_n=1:
  - count increments by 1 and wraps 3 to 0.
  - accum becomes (accum + shifted partial product) mod 2^16.
- When clk_ena=0: count, accum and the operand registers hold. sclr_n is ignored.
- Partial product (combinational, from the latched operands only):
  - input_sel 0: opa[3:0]*opb[3:0]
  - input_sel 1: opa[3:0]*opb[7:4]
  - input_sel 2: opa[7:4]*opb[3:0]
  - input_sel 3: opa[7:4]*opb[7:4]
  - The result is an 8-bit unsigned value, zero-extended to 16 bits.
- Shift:
  - shift_sel 0: shift by 0
  - shift_sel 1: shift left by 4
  - shift_sel 2: shift left by 8
  - shift_sel 3: reserved. The shifted value is forced to 0, and sel_err is set if this coincides with a step event.
- X/undefined selects outside step events must not affect any register.
- Latency:
  - The accum update is visible one cycle after the step edge.
  - product and result_valid update one cycle after the done edge.
  - The full sequence from the FSM is: clear, then 4 steps, then done.
- Result handshake:
  - done=1: product <= accum and result_valid <= 1.
  - If result_valid=1 and result_ack=0 in the same cycle, overrun <= 1.
  - result_ack=1 with done=0 and result_valid=1: result_valid <= 0; product holds its value.
  - done and result_ack in the same cycle: the capture wins and result_valid stays 1. This does not count as overrun.
  - result_ack with result_valid=0 is ignored.
- A clear event during an unconsumed result does not disturb product or result_valid.
- Arithmetic: unsigned throughout. A valid 4-step sequence cannot exceed 0xFE01, so there is no carry out.

Test Plan:
- Reset then idle: hold reset_a 2 cycles -> all outputs 0. Toggling dataa/datab with clk_ena=0 -> no change.
- 0x12*0x34: clear, then steps (sel,shift) = (0,0),(1,1),(2,1),(3,2) -> accum = 0x0008, 0x0068, 0x00A8, 0x03A8; count = 1,2,3,0. Then done -> product=0x03A8, result_valid=1.
- 0xFF*0xFF full sequence -> product=0xFE01. Change dataa to 0x00 mid-sequence -> result still 0xFE01 because operands are latched.
- Handshake: result valid, assert done again without ack -> overrun=1, product replaced. Done and ack in the same cycle -> result_valid stays 1, overrun unchanged. Ack alone -> result_valid=0.
- Step with shift_sel=3 -> accum unchanged, sel_err=1. Next clear event -> sel_err=0.
- Reset asserted after step 2 of 0x12*0x34 -> count=0 and accum=0 next cycle. A fresh sequence then yields the correct product.
